pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//   Program-counter stage and branch/jump redirect logic.
//   - Consumes the ID-stage word offset (sign-extended immediate already shifted left by 2).
//   - Forms the branch target, or the jump target, and selects the next PC.
//   - Holds the PC under stall and remembers a redirect that arrives while IF is stalled.
//   - Feeds the instruction-memory address, and the IF/ID pipeline register via pc_plus4 and flush_ifid.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//   CNT_W         16             width of taken-redirect performance counter
// PORTS
//   clk             in   1      single clock, rising edge
//   reset_n         in   1      synchronous, active-low reset
//   stall           in   1      hazard unit: hold PC this cycle
//   id_pc_plus4     in   32     PC+4 of instruction currently in ID
//   id_imm_shifted  in   32     sign-extended branch offset << 2
//   id_branch       in   1      ID instruction is a conditional branch
//   id_branch_taken in   1      ID comparator result
//   id_jump         in   1      ID instruction is J/JAL
//   id_jump_index   in   26     J-format instr_index field
//   pc              out  32     current fetch address (registered)
//   pc_plus4        out  32     pc + 4, combinational
//   flush_ifid      out  1      squash the IF/ID register this cycle
//   redirect_cnt    out  CNT_W  count of accepted redirects, saturating
// BEHAVIOUR
//   Reset, sampled on the clk edge while reset_n==0:
//     - pc=RESET_VECTOR, state=RUN, pend_target=0, redirect_cnt=0.
//     - Reset overrides every other input, including a pending redirect.
//   Target formation (combinational, modulo 2^32):
//     - br_tgt = id_pc_plus4 + id_imm_shifted; wrap-around is silent, no overflow flag.
//     - j_tgt = {id_pc_plus4[31:28], id_jump_index, 2'b00}.
//     - redirect = id_jump | (id_branch & id_branch_taken).
//     - target = id_jump ? j_tgt : br_tgt; jump wins if both are asserted.
//   FSM, two states:
//     RUN:
//       - flush_ifid = redirect.
//       - redirect & !stall  -> pc<=target, stay RUN.
//       - redirect & stall   -> pend_target<=target, pc held, go PENDING.
//       - !redirect & !stall -> pc<=pc+4.
//       - !redirect & stall  -> pc held.
//     PENDING:
//       - flush_ifid = 1 every cycle, so no wrong-path fetch enters ID.
//       - ID inputs are ignored: the ID instruction is wrong-path.
//       - stall -> hold pc and pend_target.
//       - !stall -> pc<=pend_target, go RUN.
//   Redirect latency: the target is fetched on the cycle after the redirect edge (one-slot penalty, covered by flush).
//   redirect_cnt:
//     - +1 on each RUN-state redirect, whether stalled or not.
//     - The PENDING->RUN transition is not counted again.
//     - Saturates at all-ones.
//   pc_plus4 is always pc+4; it wraps 32'hFFFF_FFFC -> 32'h0000_0000.
// STRUCTURE
//   Shared package holds:
//     - state encoding RUN=1'b0, PENDING=1'b1.
//     - PC_INC=32'd4.
//     - MIPS field widths (JIDX_W=26).
//   One combinational sub-module, branch_target_calc:
//     - inputs: id_pc_plus4, id_imm_shifted, id_jump_index, id_jump.
//     - output: target.
//   The PC register, FSM and counter stay in pc_branch_unit.
// TESTING
//   Reset, then run 3 unstalled cycles:
//     - pc = 0x0, 0x4, 0x8, 0xC.
//     - flush_ifid = 0 throughout.
//     - redirect_cnt = 0.
//   Taken branch, no stall:
//     - id_pc_plus4=0x100, id_imm_shifted=0xFFFF_FFF0, branch & taken.
//     - flush_ifid=1 that cycle.
//     - next pc=0x0F0.
//     - redirect_cnt=1.
//   Jump with stall held 2 cycles:
//     - id_pc_plus4=0x4000_0010, index=0x0000040.
//     - PENDING for 2 cycles, flush_ifid=1, pc held.
//     - On stall release, pc=0x4000_0100.
//   Branch and jump both asserted:
//     - pc takes j_tgt.
//   Not-taken branch:
//     - pc+4 path taken.
//     - No flush.
//     - Counter unchanged.
//   reset_n low while in PENDING:
//     - pc=RESET_VECTOR next edge.
//     - state=RUN.
//     - Pending target discarded.
//   Counter saturation:
//     - Force CNT_W=4 and apply 20 redirects.
//     - redirect_cnt stays at 4'hF.

Source files
------------

// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - shared types and constants for the PC / branch redirect stage
package pc_branch_unit_pkg;

    localparam int ADDR_W = 32;
    localparam int JIDX_W = 26;
    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } pc_state_t;

    // Absolute J-format target: keep the segment bits of the delay-slot PC.
    function automatic logic [ADDR_W-1:0] jump_target(
        input logic [ADDR_W-1:0] pc_plus4,
        input logic [JIDX_W-1:0] index
    );
        return {pc_plus4[ADDR_W-1:ADDR_W-4], index, 2'b00};
    endfunction

endpackage

// File: rtl/pc_branch_unit_branch_target_calc.sv
// rtl/pc_branch_unit_branch_target_calc.sv - combinational branch/jump target selection
module branch_target_calc
    import pc_branch_unit_pkg::*;
(
    input  logic [ADDR_W-1:0] id_pc_plus4,
    input  logic [ADDR_W-1:0] id_imm_shifted,
    input  logic [JIDX_W-1:0] id_jump_index,
    input  logic              id_jump,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;

    // Relative targets wrap modulo 2^32 with no overflow indication.
    assign br_tgt = id_pc_plus4 + id_imm_shifted;
    assign j_tgt  = jump_target(id_pc_plus4, id_jump_index);
    assign target = id_jump ? j_tgt : br_tgt;

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter register, redirect FSM and taken-redirect counter
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [31:0]       id_pc_plus4,
    input  logic [31:0]       id_imm_shifted,
    input  logic              id_branch,
    input  logic              id_branch_taken,
    input  logic              id_jump,
    input  logic [25:0]       id_jump_index,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              flush_ifid,
    output logic [CNT_W-1:0]  redirect_cnt
);

    pc_state_t        state_q;
    pc_state_t        state_d;
    logic [31:0]      pc_d;
    logic [31:0]      pend_target_q;
    logic [31:0]      pend_target_d;
    logic [31:0]      target;
    logic             redirect;
    logic             cnt_inc;

    branch_target_calc u_target (
        .id_pc_plus4    (id_pc_plus4),
        .id_imm_shifted (id_imm_shifted),
        .id_jump_index  (id_jump_index),
        .id_jump        (id_jump),
        .target         (target)
    );

    assign redirect = id_jump | (id_branch & id_branch_taken);
    assign pc_plus4 = pc + PC_INC;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RUN;
            pc            <= RESET_VECTOR;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pc            <= pc_d;
            pend_target_q <= pend_target_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc;
        pend_target_d = pend_target_q;
        case (state_q)
            RUN: begin
                if (redirect && stall) begin
                    pend_target_d = target;
                    state_d       = PENDING;
                end else if (!stall) begin
                    pc_d = redirect ? target : pc_plus4;
                end
            end
            PENDING: begin
                // The ID instruction here is wrong-path; only the saved target matters.
                if (!stall) begin
                    pc_d    = pend_target_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        flush_ifid = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            RUN: begin
                flush_ifid = redirect;
                cnt_inc    = redirect;
            end
            PENDING: flush_ifid = 1'b1;
            default: flush_ifid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            redirect_cnt <= '0;
        end else if (cnt_inc && (redirect_cnt != {CNT_W{1'b1}})) begin
            redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - scoreboard bench for pc_branch_unit with directed vectors
module tb_pc_branch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_imm_shifted;
    logic        id_branch;
    logic        id_branch_taken;
    logic        id_jump;
    logic [25:0] id_jump_index;

    logic [31:0] pc, pc_plus4, pc_s, pc_plus4_s;
    logic        flush_ifid, flush_ifid_s;
    logic [15:0] redirect_cnt;
    logic [3:0]  redirect_cnt_s;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        flush;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pc_branch_unit #(.RESET_VECTOR(32'h0), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .id_pc_plus4(id_pc_plus4), .id_imm_shifted(id_imm_shifted),
        .id_branch(id_branch), .id_branch_taken(id_branch_taken),
        .id_jump(id_jump), .id_jump_index(id_jump_index),
        .pc(pc), .pc_plus4(pc_plus4), .flush_ifid(flush_ifid),
        .redirect_cnt(redirect_cnt)
    );

    pc_branch_unit #(.RESET_VECTOR(32'h0), .CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .id_pc_plus4(id_pc_plus4), .id_imm_shifted(id_imm_shifted),
        .id_branch(id_branch), .id_branch_taken(id_branch_taken),
        .id_jump(id_jump), .id_jump_index(id_jump_index),
        .pc(pc_s), .pc_plus4(pc_plus4_s), .flush_ifid(flush_ifid_s),
        .redirect_cnt(redirect_cnt_s)
    );

    task automatic chk(input string name, input string field,
                       input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s %s: got %h want %h", name, field, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input string name, input logic rn, input logic st,
                        input logic br, input logic tk, input logic j,
                        input logic [31:0] p4, input logic [31:0] imm,
                        input logic [25:0] idx, input logic [31:0] e_pc,
                        input logic e_fl, input logic [15:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rn; stall = st; id_branch = br; id_branch_taken = tk;
        id_jump = j; id_pc_plus4 = p4; id_imm_shifted = imm; id_jump_index = idx;
        e.name  = name;
        e.pc    = e_pc;
        e.flush = e_fl;
        e.cnt   = e_cnt;
        e.cnt4  = (e_cnt > 16'd15) ? 4'hF : e_cnt[3:0];
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                chk(e.name, "pc", pc, e.pc);
                chk(e.name, "pc_plus4", pc_plus4, e.pc + 32'd4);
                chk(e.name, "flush_ifid", {31'b0, flush_ifid}, {31'b0, e.flush});
                chk(e.name, "redirect_cnt", {16'b0, redirect_cnt}, {16'b0, e.cnt});
                chk(e.name, "pc_sat", pc_s, e.pc);
                chk(e.name, "redirect_cnt_sat", {28'b0, redirect_cnt_s}, {28'b0, e.cnt4});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset_n = 1'b0; stall = 1'b0; id_branch = 1'b0; id_branch_taken = 1'b0;
        id_jump = 1'b0; id_pc_plus4 = '0; id_imm_shifted = '0; id_jump_index = '0;
        repeat (2) @(posedge clk);

        //   name            rn st br tk j  pc_plus4      imm           idx        exp_pc        fl cnt
        step("reset_state",  1, 0, 0, 0, 0, 32'h0,        32'h0,        26'h0,     32'h0,        0, 0);
        step("seq_4",        1, 0, 0, 0, 0, 32'h0,        32'h0,        26'h0,     32'h4,        0, 0);
        step("seq_8",        1, 0, 0, 0, 0, 32'h0,        32'h0,        26'h0,     32'h8,        0, 0);
        step("br_taken",     1, 0, 1, 1, 0, 32'h100,      32'hFFFF_FFF0,26'h0,     32'hC,        1, 0);
        step("jmp_stall",    1, 1, 0, 0, 1, 32'h4000_0010,32'h0,        26'h40,    32'hF0,       1, 1);
        step("pend_hold",    1, 1, 0, 0, 1, 32'h0,        32'h0,        26'h3FF,   32'hF0,       1, 2);
        step("pend_release", 1, 0, 1, 1, 0, 32'h800,      32'h4,        26'h0,     32'hF0,       1, 2);
        step("br_and_jmp",   1, 0, 1, 1, 1, 32'h200,      32'h10,       26'h123,   32'h4000_0100,1, 2);
        step("br_not_taken", 1, 0, 1, 0, 0, 32'h490,      32'h40,       26'h0,     32'h48C,      0, 3);
        step("plain_stall",  1, 1, 0, 0, 0, 32'h0,        32'h0,        26'h0,     32'h490,      0, 3);
        step("jmp_stall2",   1, 1, 0, 0, 1, 32'h1000_0000,32'h0,        26'h1,     32'h490,      1, 3);
        step("reset_in_pend",0, 1, 0, 0, 0, 32'h0,        32'h0,        26'h0,     32'h490,      1, 4);
        step("after_reset",  1, 0, 0, 0, 0, 32'h0,        32'h0,        26'h0,     32'h0,        0, 0);
        step("br_wrap_tgt",  1, 0, 1, 1, 0, 32'h8,        32'hFFFF_FFF4,26'h0,     32'h4,        1, 0);
        step("pc_top",       1, 0, 0, 0, 0, 32'h0,        32'h0,        26'h0,     32'hFFFF_FFFC,0, 1);
        for (int k = 0; k < 20; k++) begin
            step("sat_jump",  1, 0, 0, 0, 1, 32'h0,        32'h0,        26'h0,     32'h0,        1, 16'(1 + k));
        end
        step("sat_final",    1, 0, 0, 0, 0, 32'h0,        32'h0,        26'h0,     32'h0,        0, 21);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
